// File: rtl/corePckg.sv
// Shared types and constants for the load/store path.
package corePckg;

  localparam int unsigned cXLEN     = 32;
  localparam int unsigned cNumLanes = cXLEN / 8;
  localparam int unsigned cRegAddrW = 5;

  // funct3 encodings for loads and stores
  localparam logic [2:0] cLB  = 3'b000;
  localparam logic [2:0] cLH  = 3'b001;
  localparam logic [2:0] cLW  = 3'b010;
  localparam logic [2:0] cLBU = 3'b100;
  localparam logic [2:0] cLHU = 3'b101;
  localparam logic [2:0] cSB  = 3'b000;
  localparam logic [2:0] cSH  = 3'b001;
  localparam logic [2:0] cSW  = 3'b010;

  typedef struct packed {
    logic [cXLEN-1:0]     addr;
    logic [cXLEN-1:0]     data;
    logic [cRegAddrW-1:0] rdAddr;
    logic [2:0]           opType;
    logic                 read;
    logic                 write;
  } tMemOp;

  typedef struct packed {
    logic                 dv;
    logic [cRegAddrW-1:0] addr;
    logic [cXLEN-1:0]     data;
  } tRegOp;

  typedef enum logic [1:0] {
    eNoFault  = 2'd0,
    eMisalign = 2'd1,
    eBadFunct = 2'd2,
    eBadCmd   = 2'd3
  } tMemFault;

  typedef enum logic [1:0] {
    eIdle  = 2'd0,
    eWrite = 2'd1,
    eRead  = 2'd2,
    eWait  = 2'd3
  } tMemState;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores and alignment/extension for loads.
module load_store_align
  import corePckg::*;
(
  input  logic [2:0]           i_funct3,
  input  logic [1:0]           i_off,
  input  logic [cXLEN-1:0]     i_wdata,
  input  logic [cXLEN-1:0]     i_rdata,
  output logic [cNumLanes-1:0] o_be,
  output logic [cXLEN-1:0]     o_wdata,
  output logic [cXLEN-1:0]     o_ldata,
  output logic                 o_misalign
);

  logic [cXLEN-1:0] w_raw;

  // Store lanes and access-size alignment check
  always_comb begin
    o_be       = '0;
    o_wdata    = '0;
    o_misalign = 1'b0;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be       = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
        o_misalign = i_off[0];
      end
      2'b10: begin
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        o_misalign = (i_off != 2'b00);
      end
      default: ;
    endcase
  end

  // Shift the addressed bytes down and extend per funct3
  always_comb begin
    w_raw   = i_rdata >> {i_off, 3'b000};
    o_ldata = '0;
    case (i_funct3)
      cLB:     o_ldata = {{(cXLEN-8){w_raw[7]}}, w_raw[7:0]};
      cLBU:    o_ldata = {{(cXLEN-8){1'b0}}, w_raw[7:0]};
      cLH:     o_ldata = {{(cXLEN-16){w_raw[15]}}, w_raw[15:0]};
      cLHU:    o_ldata = {{(cXLEN-16){1'b0}}, w_raw[15:0]};
      cLW:     o_ldata = w_raw;
      default: o_ldata = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Load/store responder: one request at a time, registered memory port,
// load write-back after cMemLat cycles, faults reported without memory access.
module data_mem_unit
  import corePckg::*;
#(
  parameter int unsigned cMemLat = 1
)
(
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iMemOpValid,
  input  tMemOp                iMemOp,
  output logic                 oReady,
  output logic [cXLEN-1:0]     oMemAddr,
  output logic                 oMemRe,
  output logic                 oMemWe,
  output logic [cNumLanes-1:0] oMemBe,
  output logic [cXLEN-1:0]     oMemWData,
  input  logic [cXLEN-1:0]     iMemRData,
  output tRegOp                oRegOp,
  output logic                 oFault,
  output tMemFault             oFaultCause,
  output logic [cXLEN-1:0]     oFaultAddr
);

  localparam int unsigned cCntW = 3;
  localparam logic [cCntW-1:0] cWaitInit = cCntW'(cMemLat - 1);

  tMemState            r_state, w_state_nxt;
  logic [cCntW-1:0]    r_wait_cnt, w_wait_cnt_nxt;
  logic [2:0]          r_funct3;
  logic [1:0]          r_off;
  logic [cRegAddrW-1:0] r_rd;

  logic                 w_accept, w_bad_cmd, w_bad_funct, w_misalign, w_is_fault;
  logic                 w_do_store, w_do_load, w_load_done;
  tMemFault             w_cause;
  logic [2:0]           w_sel_funct3;
  logic [1:0]           w_sel_off;
  logic [cNumLanes-1:0] w_al_be;
  logic [cXLEN-1:0]     w_al_wdata, w_al_ldata;
  logic                 w_al_misalign;

  logic [cXLEN-1:0]     w_mem_addr_nxt, w_mem_wdata_nxt, w_fault_addr_nxt;
  logic                 w_mem_re_nxt, w_mem_we_nxt, w_fault_nxt;
  logic [cNumLanes-1:0] w_mem_be_nxt;
  tMemFault             w_fault_cause_nxt;
  tRegOp                w_reg_op_nxt;

  assign oReady      = (r_state == eIdle);
  assign w_accept    = iMemOpValid && oReady;
  assign w_load_done = (r_state == eWait) && (r_wait_cnt == '0);

  // Aligner sees the incoming request in IDLE, the captured load otherwise
  assign w_sel_funct3 = (r_state == eIdle) ? iMemOp.opType      : r_funct3;
  assign w_sel_off    = (r_state == eIdle) ? iMemOp.addr[1:0]   : r_off;

  load_store_align u_align (
    .i_funct3   (w_sel_funct3),
    .i_off      (w_sel_off),
    .i_wdata    (iMemOp.data),
    .i_rdata    (iMemRData),
    .o_be       (w_al_be),
    .o_wdata    (w_al_wdata),
    .o_ldata    (w_al_ldata),
    .o_misalign (w_al_misalign)
  );

  // Request classification with priority BadCmd > BadFunct > Misalign
  always_comb begin
    w_bad_cmd   = iMemOp.read && iMemOp.write;
    w_bad_funct = 1'b0;
    if (!w_bad_cmd && iMemOp.read)
      w_bad_funct = (iMemOp.opType == 3'b011) || (iMemOp.opType == 3'b110) ||
                    (iMemOp.opType == 3'b111);
    else if (!w_bad_cmd && iMemOp.write)
      w_bad_funct = (iMemOp.opType >= 3'b011);
    w_misalign = (iMemOp.read ^ iMemOp.write) && w_al_misalign;
    if (w_bad_cmd)        w_cause = eBadCmd;
    else if (w_bad_funct) w_cause = eBadFunct;
    else if (w_misalign)  w_cause = eMisalign;
    else                  w_cause = eNoFault;
    w_is_fault = (w_cause != eNoFault);
    w_do_store = w_accept && !w_is_fault && iMemOp.write && !iMemOp.read;
    w_do_load  = w_accept && !w_is_fault && iMemOp.read && !iMemOp.write;
  end

  // State and wait-counter register
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state    <= eIdle;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      eIdle: begin
        if (w_do_store)     w_state_nxt = eWrite;
        else if (w_do_load) w_state_nxt = eRead;
      end
      eWrite: w_state_nxt = eIdle;
      eRead: begin
        w_state_nxt    = eWait;
        w_wait_cnt_nxt = cWaitInit;
      end
      eWait: begin
        if (r_wait_cnt == '0) w_state_nxt = eIdle;
        else                  w_wait_cnt_nxt = r_wait_cnt - 1'b1;
      end
      default: w_state_nxt = eIdle;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_mem_addr_nxt    = '0;
    w_mem_re_nxt      = 1'b0;
    w_mem_we_nxt      = 1'b0;
    w_mem_be_nxt      = '0;
    w_mem_wdata_nxt   = '0;
    w_fault_nxt       = 1'b0;
    w_fault_cause_nxt = eNoFault;
    w_fault_addr_nxt  = '0;
    w_reg_op_nxt      = '0;
    if (w_accept && w_is_fault) begin
      w_fault_nxt       = 1'b1;
      w_fault_cause_nxt = w_cause;
      w_fault_addr_nxt  = iMemOp.addr;
    end else if (w_do_store) begin
      w_mem_we_nxt    = 1'b1;
      w_mem_addr_nxt  = {iMemOp.addr[cXLEN-1:2], 2'b00};
      w_mem_be_nxt    = w_al_be;
      w_mem_wdata_nxt = w_al_wdata;
    end else if (w_do_load) begin
      w_mem_re_nxt   = 1'b1;
      w_mem_addr_nxt = {iMemOp.addr[cXLEN-1:2], 2'b00};
    end
    if (w_load_done && (r_rd != '0)) begin
      w_reg_op_nxt.dv   = 1'b1;
      w_reg_op_nxt.addr = r_rd;
      w_reg_op_nxt.data = w_al_ldata;
    end
  end

  // Output registers
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oMemAddr    <= '0;
      oMemRe      <= 1'b0;
      oMemWe      <= 1'b0;
      oMemBe      <= '0;
      oMemWData   <= '0;
      oFault      <= 1'b0;
      oFaultCause <= eNoFault;
      oFaultAddr  <= '0;
      oRegOp      <= '0;
    end else begin
      oMemAddr    <= w_mem_addr_nxt;
      oMemRe      <= w_mem_re_nxt;
      oMemWe      <= w_mem_we_nxt;
      oMemBe      <= w_mem_be_nxt;
      oMemWData   <= w_mem_wdata_nxt;
      oFault      <= w_fault_nxt;
      oFaultCause <= w_fault_cause_nxt;
      oFaultAddr  <= w_fault_addr_nxt;
      oRegOp      <= w_reg_op_nxt;
    end
  end

  // Capture load attributes needed at write-back time
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_funct3 <= '0;
      r_off    <= '0;
      r_rd     <= '0;
    end else if (w_do_load) begin
      r_funct3 <= iMemOp.opType;
      r_off    <= iMemOp.addr[1:0];
      r_rd     <= iMemOp.rdAddr;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: two instances (latency 1 and 3), each with
// directed cases, a mid-load reset and random traffic against a cycle model.
module tb_data_mem_unit;
  import corePckg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_ok   = 0;
  int n_done = 0;

  typedef struct {
    logic        re, we, fault;
    logic [31:0] addr, wdata, faddr;
    logic [3:0]  be;
    tMemFault    cause;
  } exp_t;

  typedef struct {
    logic [1:0] off;
    logic [2:0] f3;
    logic [4:0] rd;
    int         samp;
  } ld_t;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.re = 0; e.we = 0; e.fault = 0; e.addr = 0; e.wdata = 0;
    e.faddr = 0; e.be = 0; e.cause = eNoFault;
    return e;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // 0 drop, 1 fault, 2 store, 3 load
  function automatic int classify(input tMemOp o, output tMemFault cause);
    int  nb;
    bit  mis;
    nb    = nbytes(o.opType);
    mis   = (int'(o.addr[1:0]) % nb) != 0;
    cause = eNoFault;
    if (o.read && o.write) begin cause = eBadCmd; return 1; end
    if (o.read) begin
      if (o.opType == 3 || o.opType == 6 || o.opType == 7) begin cause = eBadFunct; return 1; end
      if (mis) begin cause = eMisalign; return 1; end
      return 3;
    end
    if (o.write) begin
      if (o.opType >= 3) begin cause = eBadFunct; return 1; end
      if (mis) begin cause = eMisalign; return 1; end
      return 2;
    end
    return 0;
  endfunction

  function automatic logic [31:0] ld_value(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] raw, mask;
    int nb;
    nb   = nbytes(f3);
    raw  = w >> (8 * off);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    raw  = raw & mask;
    if (!f3[2] && nb < 4 && raw[8*nb-1]) raw = raw | ~mask;
    return raw;
  endfunction

  function automatic tMemOp mk(input logic r, input logic w, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    tMemOp o;
    o.read = r; o.write = w; o.opType = f3; o.addr = a; o.data = d; o.rdAddr = rd;
    return o;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int LI = (g == 0) ? 1 : 3;

    logic        rst, valid, ready, mem_re, mem_we, fault;
    tMemOp       op;
    logic [31:0] rdata, mem_addr, mem_wdata, fault_addr;
    logic [3:0]  mem_be;
    tRegOp       reg_op;
    tMemFault    fault_cause;

    data_mem_unit #(.cMemLat(LI)) u_dut (
      .iClk        (clk),
      .iRst        (rst),
      .iMemOpValid (valid),
      .iMemOp      (op),
      .oReady      (ready),
      .oMemAddr    (mem_addr),
      .oMemRe      (mem_re),
      .oMemWe      (mem_we),
      .oMemBe      (mem_be),
      .oMemWData   (mem_wdata),
      .iMemRData   (rdata),
      .oRegOp      (reg_op),
      .oFault      (fault),
      .oFaultCause (fault_cause),
      .oFaultAddr  (fault_addr)
    );

    exp_t        exp_q[int];
    ld_t         ld_q[int];
    bit          rdy_q[int];
    logic [31:0] rd_hist[int];
    int          cyc = 0;
    int          ready_cycle = 0;
    bit          cmp_en = 0;

    // Drive one cycle, advance the model on accept, then move to the next cycle
    task automatic step(input bit v, input tMemOp o, input bit use_rd, input logic [31:0] rdv);
      int       kind;
      tMemFault cs;
      exp_t     e;
      ld_t      l;
      valid = v;
      op    = o;
      rdata = use_rd ? rdv : $urandom;
      rd_hist[cyc] = rdata;
      rdy_q[cyc]   = (cyc >= ready_cycle);
      if (v && !rst && cyc >= ready_cycle) begin
        kind = classify(o, cs);
        e    = zero_exp();
        if (kind == 1) begin
          e.fault = 1; e.cause = cs; e.faddr = o.addr;
          exp_q[cyc+1] = e;
        end else if (kind == 2) begin
          e.we   = 1;
          e.addr = {o.addr[31:2], 2'b00};
          e.be   = 4'(((32'd1 << nbytes(o.opType)) - 32'd1) << o.addr[1:0]);
          case (nbytes(o.opType))
            1:       e.wdata = o.data[7:0] * 32'h0101_0101;
            2:       e.wdata = o.data[15:0] * 32'h0001_0001;
            default: e.wdata = o.data;
          endcase
          exp_q[cyc+1] = e;
          ready_cycle  = cyc + 2;
        end else if (kind == 3) begin
          e.re   = 1;
          e.addr = {o.addr[31:2], 2'b00};
          exp_q[cyc+1] = e;
          l.off = o.addr[1:0]; l.f3 = o.opType; l.rd = o.rdAddr; l.samp = cyc + 1 + LI;
          ld_q[cyc+2+LI] = l;
          ready_cycle    = cyc + 2 + LI;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    endtask

    task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
    endtask

    // Per-cycle comparison of every output against the model
    exp_t        ce;
    ld_t         cl;
    logic [37:0] cex;
    always @(negedge clk) begin
      if (cmp_en && !rst) begin
        ce  = exp_q.exists(cyc) ? exp_q[cyc] : zero_exp();
        cex = '0;
        if (ld_q.exists(cyc)) begin
          cl = ld_q[cyc];
          if (cl.rd != 0) cex = {1'b1, cl.rd, ld_value(cl.f3, cl.off, rd_hist[cl.samp])};
        end
        chk($sformatf("L%0d.c%0d.ready", LI, cyc), 128'(ready), 128'(rdy_q[cyc]));
        chk($sformatf("L%0d.c%0d.strobe_be", LI, cyc), {mem_re, mem_we, mem_be}, {ce.re, ce.we, ce.be});
        chk($sformatf("L%0d.c%0d.mem_addr", LI, cyc), 128'(mem_addr), 128'(ce.addr));
        chk($sformatf("L%0d.c%0d.mem_wdata", LI, cyc), 128'(mem_wdata), 128'(ce.wdata));
        chk($sformatf("L%0d.c%0d.fault", LI, cyc), {fault, fault_cause, fault_addr},
            {ce.fault, ce.cause, ce.faddr});
        chk($sformatf("L%0d.c%0d.regop", LI, cyc), 128'(reg_op), 128'(cex));
      end
    end

    initial begin
      tMemOp o;
      int    r;
      logic [31:0] a;
      rst = 1'b1; valid = 1'b0; op = '0; rdata = '0;
      idle(2);
      chk($sformatf("L%0d.rst.ready", LI), 128'(ready), 128'd1);
      chk($sformatf("L%0d.rst.outs", LI), 128'({mem_re, mem_we, fault, |mem_be, |mem_addr,
          |mem_wdata, |fault_addr, |fault_cause, |reg_op}), 128'd0);
      rst = 1'b0; ready_cycle = cyc; cmp_en = 1'b1;

      // SW 0x100
      step(1'b1, mk(0, 1, cSW, 32'h100, 32'hDEAD_BEEF, 5'd0), 1'b0, '0);
      chk($sformatf("L%0d.sw.we", LI), 128'(mem_we), 128'd1);
      chk($sformatf("L%0d.sw.addr", LI), 128'(mem_addr), 128'h100);
      chk($sformatf("L%0d.sw.be", LI), 128'(mem_be), 128'hF);
      chk($sformatf("L%0d.sw.wdata", LI), 128'(mem_wdata), 128'hDEAD_BEEF);
      chk($sformatf("L%0d.sw.busy", LI), 128'(ready), 128'd0);
      idle(1);
      chk($sformatf("L%0d.sw.ready_again", LI), 128'(ready), 128'd1);

      // LB / LBU at 0x103 against word 0x80FF1234
      for (int k = 0; k < 2; k++) begin
        step(1'b1, mk(1, 0, (k == 0) ? cLB : cLBU, 32'h103, 32'h0, 5'd5), 1'b0, '0);
        idle(LI);
        step(1'b0, '0, 1'b1, 32'h80FF_1234);
        chk($sformatf("L%0d.lb%0d.dv", LI, k), 128'(reg_op.dv), 128'd1);
        chk($sformatf("L%0d.lb%0d.rd", LI, k), 128'(reg_op.addr), 128'd5);
        chk($sformatf("L%0d.lb%0d.data", LI, k), 128'(reg_op.data),
            (k == 0) ? 128'hFFFF_FF80 : 128'h0000_0080);
        chk($sformatf("L%0d.lb%0d.ready", LI, k), 128'(ready), 128'd1);
      end

      // SH 0x202
      step(1'b1, mk(0, 1, cSH, 32'h202, 32'h0000_ABCD, 5'd0), 1'b0, '0);
      chk($sformatf("L%0d.sh.be", LI), 128'(mem_be), 128'hC);
      chk($sformatf("L%0d.sh.wdata", LI), 128'(mem_wdata), 128'hABCD_ABCD);
      chk($sformatf("L%0d.sh.addr", LI), 128'(mem_addr), 128'h200);
      idle(1);

      // Misaligned LW then a back-to-back good LW
      step(1'b1, mk(1, 0, cLW, 32'h105, 32'h0, 5'd7), 1'b0, '0);
      chk($sformatf("L%0d.mis.fault", LI), {fault, fault_cause, fault_addr},
          {1'b1, eMisalign, 32'h105});
      chk($sformatf("L%0d.mis.re", LI), 128'(mem_re), 128'd0);
      chk($sformatf("L%0d.mis.ready", LI), 128'(ready), 128'd1);
      step(1'b1, mk(1, 0, cLW, 32'h108, 32'h0, 5'd7), 1'b0, '0);
      chk($sformatf("L%0d.lw.re", LI), {mem_re, mem_addr}, {1'b1, 32'h108});
      idle(LI + 1);

      // read+write with funct3=111
      step(1'b1, mk(1, 1, 3'b111, 32'h30, 32'h0, 5'd1), 1'b0, '0);
      chk($sformatf("L%0d.cmd.fault", LI), {fault, fault_cause, mem_re, mem_we},
          {1'b1, eBadCmd, 2'b00});
      idle(1);

      // Reset while waiting on load data
      step(1'b1, mk(1, 0, cLW, 32'h40, 32'h0, 5'd9), 1'b0, '0);
      idle(1);
      rst = 1'b1;
      #1;
      chk($sformatf("L%0d.midrst.ready", LI), 128'(ready), 128'd1);
      chk($sformatf("L%0d.midrst.outs", LI), 128'({mem_re, mem_we, fault, |mem_be, |mem_addr,
          |mem_wdata, |fault_addr, |fault_cause, |reg_op}), 128'd0);
      idle(2);
      rst = 1'b0;
      exp_q.delete(); ld_q.delete(); ready_cycle = cyc;
      for (int i = 0; i < LI + 4; i++) begin
        step(1'b0, '0, 1'b0, '0);
        chk($sformatf("L%0d.midrst.nodv%0d", LI, i), 128'(reg_op.dv), 128'd0);
      end

      // Random traffic
      for (int i = 0; i < 700; i++) begin
        r = $urandom_range(0, 9);
        a = $urandom;
        if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
        o = mk(r < 4 || r == 8, (r >= 4 && r < 8) || r == 8, 3'($urandom_range(0, 7)),
               a, $urandom, 5'($urandom));
        step($urandom_range(0, 3) != 0, o, 1'b0, '0);
      end
      idle(8);
      cmp_en = 1'b0;
      valid  = 1'b0;
      n_done++;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && n_done < 2; i++) @(posedge clk);
    if (n_done < 2) begin
      n_chk++;
      $display("FAIL timeout done=%0d exp=2", n_done);
    end
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
